// File: rtl/axis_packetizer.sv
// axis_packetizer: frames a continuous AXI4-Stream into packets of
// packet_length beats by tagging M_AXIS_tlast. Start/stop happens only on
// packet boundaries. The data path is a fully registered two-entry skid
// buffer, made of an output register plus one skid register.

module axis_packetizer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LENGTH_WIDTH     = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [LENGTH_WIDTH-1:0]     packet_length,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tlast,
  output logic [31:0]                 packet_count,
  output logic                        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [LENGTH_WIDTH-1:0] LenOne = LENGTH_WIDTH'(1);

  // Control state
  state_e                      state_q, state_d;
  logic [LENGTH_WIDTH-1:0]     cnt_q, cnt_d;
  logic [LENGTH_WIDTH-1:0]     len_q, len_d;
  logic                        s_ready_q, s_ready_d;

  // Output register and skid register
  logic                        m_valid_q, m_valid_d;
  logic [AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                        m_last_q, m_last_d;
  logic                        skid_valid_q, skid_valid_d;
  logic [AXIS_TDATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                        skid_last_q, skid_last_d;

  logic [31:0]                 pkt_cnt_q, pkt_cnt_d;

  // Handshake and framing helpers
  logic                        in_accept;
  logic                        m_xfer;
  logic                        in_last;
  logic [LENGTH_WIDTH-1:0]     pkt_len_eff;
  logic [LENGTH_WIDTH-1:0]     cur_len;

  // Beat counter: a zero length behaves as one, and the length is frozen
  // for the rest of the packet as soon as its first beat is taken.
  always_comb begin
    in_accept   = S_AXIS_tvalid && s_ready_q;
    m_xfer      = m_valid_q && M_AXIS_tready;
    pkt_len_eff = (packet_length == '0) ? LenOne : packet_length;
    cur_len     = (cnt_q == '0) ? pkt_len_eff : len_q;
    in_last     = (cnt_q == (cur_len - LenOne));
    cnt_d       = cnt_q;
    len_d       = len_q;
    if (in_accept) begin
      if (cnt_q == '0) begin
        len_d = pkt_len_eff;
      end
      cnt_d = in_last ? '0 : (cnt_q + LenOne);
    end
  end

  // Start/stop sequencing: stopping mid-packet drains to the tlast beat.
  // The decision uses the post-acceptance counter, so a tlast beat taken in
  // the same cycle that enable falls returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = (cnt_d == '0) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_accept && in_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skid buffer steering. A beat goes to the output register when that
  // register is free or being emptied this cycle, otherwise to the skid
  // register. Because intake is blocked while skid is occupied, the skid
  // register only ever refills the output register.
  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (skid_valid_q) begin
      if (m_xfer) begin
        m_valid_d    = 1'b1;
        m_data_d     = skid_data_q;
        m_last_d     = skid_last_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_accept) begin
      if (!m_valid_q || M_AXIS_tready) begin
        m_valid_d = 1'b1;
        m_data_d  = S_AXIS_tdata;
        m_last_d  = in_last;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = S_AXIS_tdata;
        skid_last_d  = in_last;
      end
    end else if (m_xfer) begin
      m_valid_d = 1'b0;
    end
    s_ready_d = !skid_valid_d && (state_d != ST_IDLE);
    pkt_cnt_d = pkt_cnt_q + ((m_xfer && m_last_q) ? 32'd1 : 32'd0);
  end

  // Control registers: FSM state, beat counter, latched length, tready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      s_ready_q <= s_ready_d;
    end
  end

  // Data path registers; reset discards any buffered beats.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  // Packets are counted when their tlast beat leaves on the M side.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign S_AXIS_tready = s_ready_q;
  assign M_AXIS_tvalid = m_valid_q;
  assign M_AXIS_tdata  = m_data_q;
  assign M_AXIS_tlast  = m_last_q;
  assign packet_count  = pkt_cnt_q;
  assign busy          = (state_q != ST_IDLE) || m_valid_q || skid_valid_q;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed testbench for axis_packetizer. Inputs change and outputs are
// sampled on the falling edge. Accepted beats are queued together with the
// tlast flag the bench expects them to carry, and each output transfer is
// checked against the head of that queue.

module tb_axis_packetizer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [15:0] packet_length;
  logic        S_AXIS_tvalid;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tready;
  logic        M_AXIS_tready;
  logic        M_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tlast;
  logic [31:0] packet_count;
  logic        busy;

  int          compared   = 0;
  int          mismatched = 0;
  int          cycleNo    = 0;
  int          firstAcc   = 0;
  int          lastAcc    = 0;
  int          c0         = 0;
  logic        offerLast;
  logic        accepted;
  logic [31:0] expData[$];
  logic        expLast[$];
  logic        prevStall;
  logic [31:0] prevData;
  logic        prevLast;

  axis_packetizer #(
    .AXIS_TDATA_WIDTH(32),
    .LENGTH_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .packet_length(packet_length),
    .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tdata(S_AXIS_tdata),
    .S_AXIS_tready(S_AXIS_tready),
    .M_AXIS_tready(M_AXIS_tready),
    .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tdata(M_AXIS_tdata),
    .M_AXIS_tlast(M_AXIS_tlast),
    .packet_count(packet_count),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Stops a hung run; the bench itself finishes in a few hundred cycles.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive M ready, check the outputs, record handshakes.
  task automatic tick(input logic mReady);
    M_AXIS_tready = mReady;
    if (prevStall) begin
      checkBit("stall_valid", M_AXIS_tvalid, 1'b1);
      checkVal("stall_data", M_AXIS_tdata, prevData);
      checkBit("stall_last", M_AXIS_tlast, prevLast);
    end
    if (expData.size() == 0) checkBit("idle_valid", M_AXIS_tvalid, 1'b0);
    if (expData.size() >= 2) checkBit("skid_full_ready", S_AXIS_tready, 1'b0);
    if (M_AXIS_tvalid && M_AXIS_tready && expData.size() > 0) begin
      checkVal("out_data", M_AXIS_tdata, expData.pop_front());
      checkBit("out_last", M_AXIS_tlast, expLast.pop_front());
    end
    accepted = S_AXIS_tvalid && S_AXIS_tready;
    if (accepted) begin
      expData.push_back(S_AXIS_tdata);
      expLast.push_back(offerLast);
      lastAcc = cycleNo;
    end
    prevStall = M_AXIS_tvalid && !M_AXIS_tready;
    prevData  = M_AXIS_tdata;
    prevLast  = M_AXIS_tlast;
    @(posedge aclk);
    @(negedge aclk);
    cycleNo++;
  endtask

  // Offer one beat until accepted. mode 0: M ready, 1: random, 2: stalled.
  task automatic sendBeat(input logic [31:0] d, input logic l, input int mode);
    logic mr;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = d;
    offerLast     = l;
    accepted      = 1'b0;
    for (int k = 0; k < 64 && !accepted; k++) begin
      mr = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      tick(mr);
    end
    if (!accepted) checkBit("accept_timeout", accepted, 1'b1);
    S_AXIS_tvalid = 1'b0;
  endtask

  // Let every queued beat leave with M ready held high.
  task automatic drainOut();
    for (int k = 0; k < 64 && expData.size() > 0; k++) begin
      tick(1'b1);
    end
    checkVal("drain_left", 32'(expData.size()), 32'd0);
    checkBit("drain_valid", M_AXIS_tvalid, 1'b0);
  endtask

  initial begin
    aresetn       = 1'b0;
    enable        = 1'b0;
    packet_length = 16'd4;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tdata  = 32'd0;
    M_AXIS_tready = 1'b0;
    offerLast     = 1'b0;
    accepted      = 1'b0;
    prevStall     = 1'b0;
    prevData      = 32'd0;
    prevLast      = 1'b0;

    // Reset values
    #12;
    checkBit("rst_s_ready", S_AXIS_tready, 1'b0);
    checkBit("rst_m_valid", M_AXIS_tvalid, 1'b0);
    checkVal("rst_m_data", M_AXIS_tdata, 32'd0);
    checkBit("rst_m_last", M_AXIS_tlast, 1'b0);
    checkVal("rst_count", packet_count, 32'd0);
    checkBit("rst_busy", busy, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Length 4, 12 beats, M always ready
    $display("[TB] length 4 streaming");
    enable = 1'b1;
    c0 = cycleNo;
    sendBeat(32'd1, 1'b0, 0);
    firstAcc = lastAcc;
    checkVal("ready_rise_delay", 32'(firstAcc - c0), 32'd1);
    checkBit("first_valid_latency", M_AXIS_tvalid, 1'b1);
    checkVal("first_data", M_AXIS_tdata, 32'd1);
    for (int i = 2; i <= 12; i++) begin
      sendBeat(32'(i), (i % 4) == 0, 0);
    end
    checkVal("throughput", 32'(lastAcc - firstAcc), 32'd11);
    drainOut();
    checkVal("count_len4", packet_count, 32'd3);

    // Length 3, 30 beats, random back-pressure
    $display("[TB] length 3 with back-pressure");
    packet_length = 16'd3;
    for (int i = 1; i <= 30; i++) begin
      sendBeat(32'(100 + i), (i % 3) == 0, 1);
    end
    drainOut();
    checkVal("count_len3", packet_count, 32'd13);

    // Stop requested after beat 2 of a 5-beat packet
    $display("[TB] stop mid-packet");
    packet_length = 16'd5;
    sendBeat(32'd201, 1'b0, 0);
    sendBeat(32'd202, 1'b0, 0);
    enable = 1'b0;
    sendBeat(32'd203, 1'b0, 0);
    sendBeat(32'd204, 1'b0, 0);
    sendBeat(32'd205, 1'b1, 0);
    checkBit("drain_ready_low", S_AXIS_tready, 1'b0);
    checkBit("busy_after_last_acc", busy, 1'b1);
    drainOut();
    checkBit("busy_fall", busy, 1'b0);
    checkVal("count_drain", packet_count, 32'd14);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = 32'd999;
    offerLast     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1);
      checkBit("idle_no_accept", accepted, 1'b0);
    end
    S_AXIS_tvalid = 1'b0;

    // Length changed from 4 to 2 mid-packet
    $display("[TB] length change mid-packet");
    enable        = 1'b1;
    packet_length = 16'd4;
    sendBeat(32'd301, 1'b0, 0);
    sendBeat(32'd302, 1'b0, 0);
    packet_length = 16'd2;
    sendBeat(32'd303, 1'b0, 0);
    sendBeat(32'd304, 1'b1, 0);
    sendBeat(32'd305, 1'b0, 0);
    sendBeat(32'd306, 1'b1, 0);
    sendBeat(32'd307, 1'b0, 0);
    sendBeat(32'd308, 1'b1, 0);
    drainOut();
    checkVal("count_len_change", packet_count, 32'd17);

    // Length 0 behaves as 1
    $display("[TB] zero length");
    packet_length = 16'd0;
    for (int i = 1; i <= 5; i++) begin
      sendBeat(32'(400 + i), 1'b1, 0);
    end
    drainOut();
    checkVal("count_len0", packet_count, 32'd22);

    // Asynchronous reset with two beats buffered
    $display("[TB] reset mid-packet");
    packet_length = 16'd4;
    sendBeat(32'd501, 1'b0, 2);
    sendBeat(32'd502, 1'b0, 2);
    checkBit("pre_reset_valid", M_AXIS_tvalid, 1'b1);
    checkBit("pre_reset_skid_full", S_AXIS_tready, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    checkBit("async_s_ready", S_AXIS_tready, 1'b0);
    checkBit("async_m_valid", M_AXIS_tvalid, 1'b0);
    checkVal("async_m_data", M_AXIS_tdata, 32'd0);
    checkBit("async_m_last", M_AXIS_tlast, 1'b0);
    checkVal("async_count", packet_count, 32'd0);
    checkBit("async_busy", busy, 1'b0);
    expData.delete();
    expLast.delete();
    prevStall = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sendBeat(32'(600 + i), i == 4, 0);
    end
    drainOut();
    checkVal("count_after_reset", packet_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Sits directly downstream of the 16-to-32-bit stream width adapter, ahead of the DMA/RAM writer.
- Takes a continuous AXI4-Stream of zero-extended samples and inserts M_AXIS_tlast every packet_length beats, so the writer sees framed transfers.
- Fully registered two-entry skid buffer on the data path; start/stop only at packet boundaries.
- Counts packets emitted.

Parameters:
- AXIS_TDATA_WIDTH, 32, data width in and out.
- LENGTH_WIDTH, 16, width of packet_length and of the internal beat counter.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- enable  in  1  start/stop request; level-sensitive.
- packet_length  in  LENGTH_WIDTH  beats per packet; sampled at the start of each packet.
- S_AXIS_tvalid  in  1  upstream beat valid.
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH  upstream data.
- S_AXIS_tready  out  1  upstream ready; registered.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tvalid  out  1  downstream valid; registered.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  downstream data; registered.
- M_AXIS_tlast  out  1  last beat of packet; registered.
- packet_count  out  32  packets fully emitted on M side; wraps 0xFFFFFFFF to 0.
- busy  out  1  high when state is not IDLE or the buffer is non-empty.

Behaviour:
- Reset (aresetn low, asynchronous):
  - S_AXIS_tready=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0.
  - packet_count=0, busy=0, state=IDLE, beat counter=0, skid entry empty.
  - Reset mid-packet discards buffered beats; no partial tlast is emitted afterwards.
- Handshake rules:
  - Input beat accepted when S_AXIS_tvalid && S_AXIS_tready.
  - Output beat transferred when M_AXIS_tvalid && M_AXIS_tready.
  - M_AXIS_tdata/tlast stable while M_AXIS_tvalid && !M_AXIS_tready.
- Skid buffer:
  - Holds an output register plus one skid register.
  - S_AXIS_tready is low when the skid register is occupied or state forbids intake.
  - Latency is 1 cycle from input acceptance to M_AXIS_tvalid when the buffer is empty.
  - Full throughput: 1 beat/cycle sustained with both sides ready.
  - When M_AXIS_tready drops, the in-flight beat goes to skid; intake resumes once skid drains.
- Beat counter and tlast:
  - Counter increments on each accepted input beat.
  - Beat with counter == len_q-1 is tagged tlast=1, then the counter returns to 0.
  - len_q is latched from packet_length when the first beat of a packet is accepted (counter==0).
  - packet_length==0 is treated as 1: every beat carries tlast.
  - The tlast tag travels with its data through the skid buffer.
- State machine:
  - IDLE: S_AXIS_tready=0. Go to RUN when enable=1; S_AXIS_tready rises the next cycle.
  - RUN: accept beats.
    - enable=0 with counter==0 → IDLE.
    - enable=0 mid-packet → DRAIN.
  - DRAIN: keep accepting until the tlast beat is accepted, then go to IDLE; enable is ignored.
  - Packets are never truncated. Re-asserting enable in DRAIN takes effect after the return to IDLE.
- Simultaneous events:
  - The tlast beat accepted in the same cycle enable falls: go straight to IDLE, no DRAIN.
  - Intake and output in the same cycle: occupancy unchanged.
- packet_count increments on output transfer of a beat with tlast=1, not on intake.

Test Plan:
- Reset, then enable=1, packet_length=4, 12 beats of data 1..12, M ready always → tlast on data 4, 8, 12; packet_count=3; one beat per cycle; first M_AXIS_tvalid 1 cycle after the first acceptance.
- packet_length=3, M_AXIS_tready toggling pseudo-randomly, 30 beats → no loss, duplication or reorder; tlast every 3rd beat; data stable while stalled; S_AXIS_tready never high with skid full.
- enable=0 after beat 2 of a 5-beat packet → beats 3–5 still accepted, tlast on beat 5, then S_AXIS_tready=0, busy falls after the last output transfer.
- packet_length changed from 4 to 2 mid-packet → current packet stays 4 beats, next packets are 2 beats.
- packet_length=0 → every beat tlast=1; packet_count equals the beat count.
- Assert aresetn=0 mid-packet with 2 beats buffered → all outputs 0 immediately (asynchronous); after release and enable, the first packet is a full packet_length beats long.
